// File: rtl/sv_dma_bus_pack.sv
// DMA upstream header layout shared by the PTC request blocks.
// Field widths are fixed maxima; narrower source fields are zero-extended.
package sv_dma_bus_pack;

  localparam int DMA_UPHDR_WIDTH = 96;

  localparam int DMA_REQUEST_LENGTH_O = 0;
  localparam int DMA_REQUEST_LENGTH_W = 11;
  localparam int DMA_REQUEST_TYPE_O   = 11;
  localparam int DMA_REQUEST_TYPE_W   = 1;
  localparam int DMA_REQUEST_UNITID_O = 16;
  localparam int DMA_REQUEST_UNITID_W = 8;
  localparam int DMA_REQUEST_TAG_O    = 24;
  localparam int DMA_REQUEST_TAG_W    = 8;
  localparam int DMA_REQUEST_GLOBAL_O = 32;
  localparam int DMA_REQUEST_GLOBAL_W = 64;

  localparam logic DMA_TYPE_READ  = 1'b0;
  localparam logic DMA_TYPE_WRITE = 1'b1;

  typedef logic [DMA_UPHDR_WIDTH-1:0] dma_uphdr_t;

  // Bits [15:12] are reserved and always zero.
  function automatic dma_uphdr_t dma_uphdr_pack(
    input logic [DMA_REQUEST_LENGTH_W-1:0] len_dw,
    input logic                            req_type,
    input logic [DMA_REQUEST_UNITID_W-1:0] unit_id,
    input logic [DMA_REQUEST_TAG_W-1:0]    tag,
    input logic [DMA_REQUEST_GLOBAL_W-1:0] addr
  );
    dma_uphdr_t hdr;
    hdr = '0;
    hdr[DMA_REQUEST_LENGTH_O +: DMA_REQUEST_LENGTH_W] = len_dw;
    hdr[DMA_REQUEST_TYPE_O]                           = req_type;
    hdr[DMA_REQUEST_UNITID_O +: DMA_REQUEST_UNITID_W] = unit_id;
    hdr[DMA_REQUEST_TAG_O +: DMA_REQUEST_TAG_W]       = tag;
    hdr[DMA_REQUEST_GLOBAL_O +: DMA_REQUEST_GLOBAL_W] = addr;
    return hdr;
  endfunction

endpackage

// File: rtl/ptc_tag_pool.sv
// Tag-in-use bitmap with round-robin allocation and an outstanding counter.
// Allocation searches the pre-release bitmap, so a tag freed this cycle is usable next cycle.
module ptc_tag_pool #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 alloc_i,
  output logic                 free_vld_o,
  output logic [TAG_WIDTH-1:0] free_tag_o,
  input  logic                 rel_vld_i,
  input  logic [TAG_WIDTH-1:0] rel_tag_i,
  output logic                 rel_err_o,
  output logic [TAG_WIDTH:0]   outstanding_o
);

  localparam int NT = 2 ** TAG_WIDTH;

  logic [NT-1:0]        in_use_q, in_use_d;
  logic [TAG_WIDTH-1:0] ptr_q, ptr_d;
  logic [TAG_WIDTH:0]   cnt_q, cnt_d;
  logic                 rel_err_q, rel_err_d;
  logic                 rel_ok;
  logic                 do_alloc;

  // Scan downwards so the free tag closest to the pointer wins.
  always_comb begin
    logic [TAG_WIDTH-1:0] idx;
    free_vld_o = 1'b0;
    free_tag_o = '0;
    idx        = '0;
    for (int i = NT - 1; i >= 0; i--) begin
      idx = ptr_q + TAG_WIDTH'(i);
      if (!in_use_q[idx]) begin
        free_vld_o = 1'b1;
        free_tag_o = idx;
      end
    end
  end

  assign do_alloc = alloc_i && free_vld_o;
  assign rel_ok   = rel_vld_i && in_use_q[rel_tag_i];

  always_comb begin
    in_use_d  = in_use_q;
    ptr_d     = ptr_q;
    rel_err_d = rel_vld_i && !in_use_q[rel_tag_i];
    if (do_alloc) begin
      in_use_d[free_tag_o] = 1'b1;
      ptr_d                = free_tag_o + 1'b1;
    end
    if (rel_ok) begin
      in_use_d[rel_tag_i] = 1'b0;
    end
    cnt_d = cnt_q + (TAG_WIDTH+1)'(do_alloc) - (TAG_WIDTH+1)'(rel_ok);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_use_q  <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      rel_err_q <= 1'b0;
    end else begin
      in_use_q  <= in_use_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rel_err_q <= rel_err_d;
    end
  end

  assign rel_err_o     = rel_err_q;
  assign outstanding_o = cnt_q;

endmodule

// File: rtl/ptc_rd_req_splitter.sv
// Splits DMA read commands into MRRS-aligned read headers, each carrying a pool tag.
// Handshake: a header transfers on a cycle where UP_MVB_SRC_RDY and UP_MVB_DST_RDY are both 1.
module ptc_rd_req_splitter
  import sv_dma_bus_pack::*;
#(
  parameter int MRRS       = 512,
  parameter int ADDR_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int TAG_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [ADDR_WIDTH-1:0]      RQ_ADDR,
  input  logic [LEN_WIDTH-1:0]       RQ_LEN,
  input  logic [ID_WIDTH-1:0]        RQ_ID,
  input  logic                       RQ_VLD,
  output logic                       RQ_RDY,
  output logic [DMA_UPHDR_WIDTH-1:0] UP_MVB_DATA,
  output logic                       UP_MVB_VLD,
  output logic                       UP_MVB_SRC_RDY,
  input  logic                       UP_MVB_DST_RDY,
  input  logic [TAG_WIDTH-1:0]       CPL_TAG,
  input  logic                       CPL_VLD,
  output logic [TAG_WIDTH:0]         OUTSTANDING,
  output logic                       REL_ERR
);

  localparam int OFFW = $clog2(MRRS);
  localparam int CW   = OFFW + 1;
  localparam int MW   = (LEN_WIDTH > CW) ? LEN_WIDTH : CW;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  dma_uphdr_t            hdr_q, hdr_d;
  logic                  src_rdy_q, src_rdy_d;

  logic [MW-1:0]         room;
  logic [MW-1:0]         rem_ext;
  logic [MW-1:0]         chunk;
  logic                  cmd_acc;
  logic                  hdr_acc;
  logic                  load;
  logic                  tag_free;
  logic [TAG_WIDTH-1:0]  tag_new;

  assign RQ_RDY  = (state_q == ST_IDLE) && !RESET;
  assign cmd_acc = RQ_VLD && RQ_RDY;
  assign hdr_acc = src_rdy_q && UP_MVB_DST_RDY;

  // Chunk stops at the next MRRS boundary or at the end of the command.
  assign room    = MW'(MRRS) - MW'(addr_q[OFFW-1:0]);
  assign rem_ext = MW'(rem_q);
  assign chunk   = (rem_ext < room) ? rem_ext : room;

  // The output register refills in the same cycle it drains, giving one header per cycle.
  assign load = (state_q == ST_ISSUE) && (rem_q != '0) && (!src_rdy_q || UP_MVB_DST_RDY) && tag_free;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    id_d      = id_q;
    hdr_d     = hdr_q;
    src_rdy_d = src_rdy_q;
    if (state_q == ST_IDLE) begin
      if (cmd_acc) begin
        addr_d = RQ_ADDR;
        rem_d  = RQ_LEN;
        id_d   = RQ_ID;
        if (RQ_LEN != '0) begin
          state_d = ST_ISSUE;
        end
      end
    end else begin
      if (load) begin
        hdr_d     = dma_uphdr_pack(DMA_REQUEST_LENGTH_W'(chunk >> 2), DMA_TYPE_READ,
                                   DMA_REQUEST_UNITID_W'(id_q), DMA_REQUEST_TAG_W'(tag_new),
                                   DMA_REQUEST_GLOBAL_W'(addr_q));
        src_rdy_d = 1'b1;
        addr_d    = addr_q + ADDR_WIDTH'(chunk);
        rem_d     = rem_q - LEN_WIDTH'(chunk);
      end else if (hdr_acc) begin
        src_rdy_d = 1'b0;
        if (rem_q == '0) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      id_q      <= '0;
      hdr_q     <= '0;
      src_rdy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      id_q      <= id_d;
      hdr_q     <= hdr_d;
      src_rdy_q <= src_rdy_d;
    end
  end

  ptc_tag_pool #(
    .TAG_WIDTH (TAG_WIDTH)
  ) u_tag_pool (
    .clk_i         (CLK),
    .reset_i       (RESET),
    .alloc_i       (load),
    .free_vld_o    (tag_free),
    .free_tag_o    (tag_new),
    .rel_vld_i     (CPL_VLD),
    .rel_tag_i     (CPL_TAG),
    .rel_err_o     (REL_ERR),
    .outstanding_o (OUTSTANDING)
  );

  assign UP_MVB_DATA    = hdr_q;
  assign UP_MVB_SRC_RDY = src_rdy_q;
  assign UP_MVB_VLD     = src_rdy_q;

endmodule

// File: tb/tb_ptc_rd_req_splitter.sv
// Bench for ptc_rd_req_splitter with a 4-tag pool: directed scenarios followed by random traffic,
// checked against a chunk/tag reference model.
module tb_ptc_rd_req_splitter;
  import sv_dma_bus_pack::*;

  localparam int MRRS = 512;
  localparam int AW   = 32;
  localparam int LW   = 16;
  localparam int TW   = 2;
  localparam int IW   = 4;
  localparam int NT   = 4;
  localparam int HW   = DMA_UPHDR_WIDTH;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [AW-1:0] RQ_ADDR = '0;
  logic [LW-1:0] RQ_LEN = '0;
  logic [IW-1:0] RQ_ID = '0;
  logic          RQ_VLD = 1'b0;
  logic          RQ_RDY;
  logic [HW-1:0] UP_MVB_DATA;
  logic          UP_MVB_VLD;
  logic          UP_MVB_SRC_RDY;
  logic          UP_MVB_DST_RDY = 1'b1;
  logic [TW-1:0] CPL_TAG = '0;
  logic          CPL_VLD = 1'b0;
  logic [TW:0]   OUTSTANDING;
  logic          REL_ERR;

  ptc_rd_req_splitter #(
    .MRRS (MRRS), .ADDR_WIDTH (AW), .LEN_WIDTH (LW), .TAG_WIDTH (TW), .ID_WIDTH (IW)
  ) dut (
    .CLK (CLK), .RESET (RESET),
    .RQ_ADDR (RQ_ADDR), .RQ_LEN (RQ_LEN), .RQ_ID (RQ_ID), .RQ_VLD (RQ_VLD), .RQ_RDY (RQ_RDY),
    .UP_MVB_DATA (UP_MVB_DATA), .UP_MVB_VLD (UP_MVB_VLD),
    .UP_MVB_SRC_RDY (UP_MVB_SRC_RDY), .UP_MVB_DST_RDY (UP_MVB_DST_RDY),
    .CPL_TAG (CPL_TAG), .CPL_VLD (CPL_VLD),
    .OUTSTANDING (OUTSTANDING), .REL_ERR (REL_ERR)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [HW-1:0] exp_q[$];
  int acc_cyc[$];
  int acc_tag[$];
  int acc_len[$];
  bit in_use[NT];
  int ptr = 0;
  bit pend_vld = 0;
  int pend_tag = 0;
  bit prev_hold = 0;
  logic [HW-1:0] prev_data = '0;
  int cur_tag = 0;
  bit rnd_mode = 0;

  task automatic chk(input string name, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int len_dw, input logic [63:0] addr, input int id);
    logic [HW-1:0] h;
    logic [31:0] l;
    logic [31:0] i;
    l = len_dw;
    i = id;
    h = '0;
    h[DMA_REQUEST_LENGTH_O +: DMA_REQUEST_LENGTH_W] = l[DMA_REQUEST_LENGTH_W-1:0];
    h[DMA_REQUEST_TYPE_O] = DMA_TYPE_READ;
    h[DMA_REQUEST_UNITID_O +: DMA_REQUEST_UNITID_W] = i[DMA_REQUEST_UNITID_W-1:0];
    h[DMA_REQUEST_GLOBAL_O +: DMA_REQUEST_GLOBAL_W] = addr;
    return h;
  endfunction

  function automatic int popcnt();
    int n = 0;
    for (int k = 0; k < NT; k++) n += int'(in_use[k]);
    return n;
  endfunction

  // Expected chunks: cut at each MRRS boundary until the length is used up.
  task automatic push_chunks(input int addr, input int len, input int id);
    int a = addr;
    int r = len;
    while (r > 0) begin
      int room = MRRS - (a % MRRS);
      int c = (r < room) ? r : room;
      exp_q.push_back(mk_hdr(c / 4, 64'(a), id));
      a += c;
      r -= c;
    end
  endtask

  // ---------------- monitor / reference model ----------------
  always @(negedge CLK) begin : monitor
    bit exp_err;
    bit found;
    int t;
    logic [HW-1:0] e;
    if (RESET) begin
      exp_q.delete();
      for (int k = 0; k < NT; k++) in_use[k] = 0;
      ptr = 0;
      pend_vld = 0;
      prev_hold = 0;
    end else begin
      exp_err = pend_vld && !in_use[pend_tag];
      chk("rel_err", REL_ERR, exp_err);
      if (prev_hold) begin
        chk("hold_src_rdy", UP_MVB_SRC_RDY, 1);
        chk("hold_data", UP_MVB_DATA, prev_data);
      end
      if (UP_MVB_SRC_RDY && !prev_hold) begin
        found = 0;
        t = 0;
        for (int k = 0; k < NT; k++) begin
          if (!found && !in_use[(ptr + k) % NT]) begin
            found = 1;
            t = (ptr + k) % NT;
          end
        end
        chk("tag_avail", found, 1);
        chk("hdr_tag", UP_MVB_DATA[DMA_REQUEST_TAG_O +: DMA_REQUEST_TAG_W], t);
        in_use[t] = 1;
        ptr = (t + 1) % NT;
        cur_tag = t;
      end
      if (pend_vld && !exp_err) in_use[pend_tag] = 0;
      chk("outstanding", OUTSTANDING, popcnt());
      chk("vld_eq_src", UP_MVB_VLD, UP_MVB_SRC_RDY);
      if (UP_MVB_SRC_RDY && UP_MVB_DST_RDY) begin
        chk("hdr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          e[DMA_REQUEST_TAG_O +: DMA_REQUEST_TAG_W] = DMA_REQUEST_TAG_W'(cur_tag);
          chk("hdr_data", UP_MVB_DATA, e);
        end
        acc_cyc.push_back(cyc);
        acc_tag.push_back(int'(UP_MVB_DATA[DMA_REQUEST_TAG_O +: DMA_REQUEST_TAG_W]));
        acc_len.push_back(int'(UP_MVB_DATA[DMA_REQUEST_LENGTH_O +: DMA_REQUEST_LENGTH_W]));
      end
      prev_hold = UP_MVB_SRC_RDY && !UP_MVB_DST_RDY;
      prev_data = UP_MVB_DATA;
      pend_vld  = CPL_VLD;
      pend_tag  = int'(CPL_TAG);
    end
  end

  // ---------------- random background traffic ----------------
  always @(posedge CLK) begin
    #1;
    if (rnd_mode) begin
      UP_MVB_DST_RDY = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        CPL_VLD = 1'b1;
        CPL_TAG = TW'($urandom_range(0, NT - 1));
      end else begin
        CPL_VLD = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge CLK); #1;
    RESET = 1'b1;
    RQ_VLD = 1'b0;
    CPL_VLD = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_rq_rdy", RQ_RDY, 0);
    chk("rst_src_rdy", UP_MVB_SRC_RDY, 0);
    chk("rst_vld", UP_MVB_VLD, 0);
    chk("rst_data", UP_MVB_DATA, 0);
    chk("rst_outstanding", OUTSTANDING, 0);
    chk("rst_rel_err", REL_ERR, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    chk("post_rst_rq_rdy", RQ_RDY, 1);
  endtask

  task automatic send_cmd(input int addr, input int len, input int id);
    bit ok = 0;
    @(posedge CLK); #1;
    RQ_ADDR = AW'(addr);
    RQ_LEN  = LW'(len);
    RQ_ID   = IW'(id);
    RQ_VLD  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (RQ_RDY) begin
        ok = 1;
        push_chunks(addr, len, id);
        break;
      end
    end
    chk("cmd_accept", ok, 1);
    @(posedge CLK); #1;
    RQ_VLD = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (RQ_RDY && !UP_MVB_SRC_RDY && exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    chk("idle_reached", done, 1);
  endtask

  task automatic rel(input int t);
    @(posedge CLK); #1;
    CPL_VLD = 1'b1;
    CPL_TAG = TW'(t);
    @(posedge CLK); #1;
    CPL_VLD = 1'b0;
  endtask

  task automatic release_all();
    for (int t = 0; t < NT; t++) if (in_use[t]) rel(t);
    repeat (2) @(negedge CLK);
  endtask

  task automatic clear_acc();
    acc_cyc.delete();
    acc_tag.delete();
    acc_len.delete();
  endtask

  task automatic wait_src(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (UP_MVB_SRC_RDY) begin
        seen = 1;
        break;
      end
    end
    chk("src_rdy_seen", seen, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [HW-1:0] d0;
    int o0;
    bit got4;

    do_reset();

    // Two aligned 512 B chunks, back to back.
    clear_acc();
    send_cmd(32'h1000, 1024, 3);
    wait_idle(50);
    chk("c1_count", acc_tag.size(), 2);
    if (acc_tag.size() >= 2) begin
      chk("c1_tag0", acc_tag[0], 0);
      chk("c1_tag1", acc_tag[1], 1);
      chk("c1_len0", acc_len[0], 128);
      chk("c1_len1", acc_len[1], 128);
      chk("c1_consecutive", acc_cyc[1] - acc_cyc[0], 1);
    end
    release_all();

    // Crossing a boundary 16 B before it.
    clear_acc();
    send_cmd(32'h11F0, 64, 5);
    wait_idle(50);
    chk("c2_count", acc_len.size(), 2);
    if (acc_len.size() >= 2) begin
      chk("c2_len0", acc_len[0], 4);
      chk("c2_len1", acc_len[1], 12);
    end
    release_all();

    // Tag exhaustion: four headers then stall until tag 0 returns.
    clear_acc();
    send_cmd(0, 2560, 1);
    got4 = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (acc_tag.size() == 4) begin
        got4 = 1;
        break;
      end
    end
    chk("c3_four_hdrs", got4, 1);
    repeat (3) begin
      @(negedge CLK);
      chk("c3_stall_src", UP_MVB_SRC_RDY, 0);
      chk("c3_stall_out", OUTSTANDING, 4);
    end
    if (acc_tag.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("c3_tag_seq", acc_tag[k], k);
    end
    rel(0);
    @(negedge CLK);
    chk("c3_out_after_rel", OUTSTANDING, 3);
    chk("c3_src_after_rel", UP_MVB_SRC_RDY, 0);
    @(negedge CLK);
    chk("c3_out_realloc", OUTSTANDING, 4);
    chk("c3_src_realloc", UP_MVB_SRC_RDY, 1);
    chk("c3_tag_realloc", UP_MVB_DATA[DMA_REQUEST_TAG_O +: DMA_REQUEST_TAG_W], 0);
    wait_idle(50);
    chk("c3_count", acc_tag.size(), 5);
    release_all();

    // Backpressure for 10 cycles mid-split.
    clear_acc();
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b0;
    send_cmd(32'h2000, 2048, 2);
    wait_src(20);
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b1;
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b0;
    @(negedge CLK);
    d0 = UP_MVB_DATA;
    o0 = int'(OUTSTANDING);
    chk("c4_out_at_hold", o0, 2);
    repeat (10) begin
      @(negedge CLK);
      chk("c4_src_stable", UP_MVB_SRC_RDY, 1);
      chk("c4_data_stable", UP_MVB_DATA, d0);
      chk("c4_out_stable", OUTSTANDING, o0);
    end
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b1;
    wait_idle(50);
    chk("c4_count", acc_tag.size(), 4);
    release_all();

    // Zero-length command and a release of a free tag.
    clear_acc();
    send_cmd(32'h3000, 0, 1);
    repeat (5) begin
      @(negedge CLK);
      chk("c5_no_hdr", UP_MVB_SRC_RDY, 0);
      chk("c5_rq_rdy", RQ_RDY, 1);
    end
    chk("c5_count", acc_tag.size(), 0);
    rel(1);
    @(negedge CLK);
    chk("c5_rel_err_pulse", REL_ERR, 1);
    chk("c5_out_unchanged", OUTSTANDING, 0);
    @(negedge CLK);
    chk("c5_rel_err_clear", REL_ERR, 0);

    // Reset after one of four chunks.
    clear_acc();
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b0;
    send_cmd(32'h4000, 2048, 7);
    wait_src(20);
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b1;
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b0;
    chk("c6_one_accepted", acc_tag.size(), 1);
    do_reset();
    @(negedge CLK);
    chk("c6_src_after_rst", UP_MVB_SRC_RDY, 0);
    chk("c6_out_after_rst", OUTSTANDING, 0);
    @(posedge CLK); #1;
    UP_MVB_DST_RDY = 1'b1;
    clear_acc();
    send_cmd(32'h40, 8, 1);
    wait_idle(50);
    chk("c6_next_count", acc_tag.size(), 1);
    if (acc_tag.size() >= 1) chk("c6_next_tag", acc_tag[0], 0);
    release_all();

    // Random traffic with random backpressure and releases.
    rnd_mode = 1;
    for (int n = 0; n < 25; n++) begin
      int a;
      int l;
      a = $urandom_range(0, 16383) * 4;
      l = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 900) * 4;
      send_cmd(a, l, $urandom_range(0, 15));
    end
    wait_idle(5000);
    rnd_mode = 0;
    @(posedge CLK); #2;
    UP_MVB_DST_RDY = 1'b1;
    CPL_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    release_all();
    @(negedge CLK);
    chk("final_outstanding", OUTSTANDING, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
